// File: rtl/anfsqrt_pkg_341449297858921043.sv
// Shared definitions for the anfsqrt squarer.
//   state_e  : FSM encoding (StIdle=0, StRun=1, StDone=2; code 3 is treated as idle)
//   DefaultW : default root width
//   SqW/CntW : square and iteration-counter widths for DefaultW
//   sq_w()/cnt_w() : the same width rules for any root width
package anfsqrt_pkg_341449297858921043;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   localparam int unsigned DefaultW = 6;
   localparam int unsigned SqW      = 2 * DefaultW;
   localparam int unsigned CntW     = $clog2(DefaultW) + 1;

   function automatic int unsigned sq_w(input int unsigned w);
      return 2 * w;
   endfunction

   function automatic int unsigned cnt_w(input int unsigned w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/anfsqrt_sqchk_341449297858921043.sv
// Combinational range check used by the squarer when ANFSQRT_SQUARE_CHECK_EN is defined.
// Tells whether op is the integer square root of query.
//   square_i  : op*op
//   op_i      : the root
//   query_i   : value op claims to be the root of
//   rem_o     : query - square, two's complement, 2W+1 bits
//   root_ok_o : square <= query < (op+1)^2
module anfsqrt_sqchk_341449297858921043
   import anfsqrt_pkg_341449297858921043::*;
#(
   parameter int unsigned W = DefaultW
) (
   input  logic [2*W-1:0] square_i,
   input  logic [W-1:0]   op_i,
   input  logic [2*W-1:0] query_i,
   output logic [2*W:0]   rem_o,
   output logic           root_ok_o
);

   logic [2*W:0] square_x;
   logic [2*W:0] query_x;
   logic [2*W:0] next_sq;

   always_comb begin
      square_x  = {1'b0, square_i};
      query_x   = {1'b0, query_i};
      // (op+1)^2 = op^2 + 2*op + 1; one extra bit so op = 2^W-1 cannot wrap
      next_sq   = square_x + {{W{1'b0}}, op_i, 1'b0} + {{(2*W){1'b0}}, 1'b1};
      rem_o     = query_x - square_x;
      root_ok_o = (square_x <= query_x) && (query_x < next_sq);
   end

endmodule

// File: rtl/anfsqrt_square_341449297858921043.sv
// Iterative shift-add squarer: one multiplier bit per cycle, W cycles per root.
// Optional feature macro: ANFSQRT_SQUARE_CHECK_EN (adds query_i/rem_o/root_ok_o).
//   clk_i, rst_i            : clock, asynchronous active-high reset
//   in_valid_i / in_ready_o : root handshake (in_ready_o high only when idle)
//   root_i                  : W-bit operand, sampled on accept
//   out_valid_o/out_ready_i : result handshake
//   square_o                : root*root, 2W bits; holds last value after handshake
//   query_i, rem_o, root_ok_o (check build only): see anfsqrt_sqchk
module anfsqrt_square_341449297858921043
   import anfsqrt_pkg_341449297858921043::*;
#(
   parameter int unsigned W = DefaultW
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           in_valid_i,
   output logic           in_ready_o,
   input  logic [W-1:0]   root_i,
   output logic           out_valid_o,
   input  logic           out_ready_i,
   output logic [2*W-1:0] square_o
`ifdef ANFSQRT_SQUARE_CHECK_EN
   ,
   input  logic [2*W-1:0] query_i,
   output logic [2*W:0]   rem_o,
   output logic           root_ok_o
`endif
);

   localparam int unsigned SqWL  = sq_w(W);
   localparam int unsigned CntWL = cnt_w(W);

   state_e            state_q;
   logic [W-1:0]      op_q;
   logic [SqWL-1:0]   acc_q;
   logic [SqWL-1:0]   acc_d;
   logic [SqWL-1:0]   pp;
   logic [W-1:0]      op_shr;
   logic [SqWL-1:0]   square_q;
   logic [CntWL-1:0]  cnt_q;
   logic              out_valid_q;
   logic              last_step;

   // Partial product for the current multiplier bit, zero-extended before shifting
   always_comb begin
      pp        = {{W{1'b0}}, op_q} << cnt_q;
      op_shr    = op_q >> cnt_q;
      acc_d     = op_shr[0] ? (acc_q + pp) : acc_q;
      last_step = (cnt_q == CntWL'(W - 1));
   end

`ifdef ANFSQRT_SQUARE_CHECK_EN
   logic [SqWL-1:0] query_q;
   logic [SqWL:0]   rem_d;
   logic [SqWL:0]   rem_q;
   logic            root_ok_d;
   logic            root_ok_q;

   // Evaluated on the final accumulator so the result lands with square_q
   anfsqrt_sqchk_341449297858921043 #(
      .W (W)
   ) u_sqchk (
      .square_i  (acc_d),
      .op_i      (op_q),
      .query_i   (query_q),
      .rem_o     (rem_d),
      .root_ok_o (root_ok_d)
   );

   assign rem_o     = rem_q;
   assign root_ok_o = root_ok_q;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         op_q        <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         square_q    <= '0;
         out_valid_q <= 1'b0;
`ifdef ANFSQRT_SQUARE_CHECK_EN
         query_q     <= '0;
         rem_q       <= '0;
         root_ok_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            StRun: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q + CntWL'(1);
               if (last_step) begin
                  square_q    <= acc_d;
                  out_valid_q <= 1'b1;
                  state_q     <= StDone;
`ifdef ANFSQRT_SQUARE_CHECK_EN
                  rem_q       <= rem_d;
                  root_ok_q   <= root_ok_d;
`endif
               end
            end
            StDone: begin
               if (out_ready_i) begin
                  out_valid_q <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            // StIdle and the unused code 3
            default: begin
               if (in_valid_i) begin
                  op_q    <= root_i;
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  state_q <= StRun;
`ifdef ANFSQRT_SQUARE_CHECK_EN
                  query_q <= query_i;
`endif
               end
            end
         endcase
      end
   end

   assign in_ready_o  = (state_q != StRun) && (state_q != StDone);
   assign out_valid_o = out_valid_q;
   assign square_o    = square_q;

endmodule

// File: tb/tb_anfsqrt_square_341449297858921043.sv
// Directed bench for the anfsqrt squarer with hand-computed expected squares.
module tb_anfsqrt_square_341449297858921043;

   localparam int unsigned W = 6;

   logic           clk_i;
   logic           rst_i;
   logic           in_valid_i;
   logic           in_ready_o;
   logic [W-1:0]   root_i;
   logic           out_valid_o;
   logic           out_ready_i;
   logic [2*W-1:0] square_o;
`ifdef ANFSQRT_SQUARE_CHECK_EN
   logic [2*W-1:0] query_i;
   logic [2*W:0]   rem_o;
   logic           root_ok_o;
`endif

   int n_checks;
   int n_fail;

   anfsqrt_square_341449297858921043 #(
      .W (W)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .root_i      (root_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .square_o    (square_o)
`ifdef ANFSQRT_SQUARE_CHECK_EN
      ,
      .query_i     (query_i),
      .rem_o       (rem_o),
      .root_ok_o   (root_ok_o)
`endif
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Present a root for one accepting edge
   task automatic accept(input logic [W-1:0] r);
      root_i     = r;
      in_valid_i = 1'b1;
      tick();
      in_valid_i = 1'b0;
   endtask

   // Count cycles after the accepting edge until out_valid, bounded
   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (!out_valid_o && cyc < 40) begin
         tick();
         cyc++;
      end
   endtask

   initial begin
      int cyc;
      int seen;
      n_checks    = 0;
      n_fail      = 0;
      rst_i       = 1'b1;
      in_valid_i  = 1'b0;
      out_ready_i = 1'b0;
      root_i      = '0;
`ifdef ANFSQRT_SQUARE_CHECK_EN
      query_i     = '0;
`endif
      tick();
      tick();
      check("rst_out_valid", out_valid_o, 0);
      check("rst_in_ready", in_ready_o, 1);
      check("rst_square", square_o, 0);
      rst_i = 1'b0;
      tick();

      // 1: root=45, out_ready already high
      out_ready_i = 1'b1;
      accept(6'd45);
      check("t1_busy_in_ready", in_ready_o, 0);
      wait_valid(cyc);
      check("t1_latency", cyc, W);
      check("t1_square", square_o, 2025);
      tick();
      check("t1_out_valid_drop", out_valid_o, 0);
      check("t1_in_ready_back", in_ready_o, 1);

      // 2: root=0 then root=63 back-to-back, in_valid left high
      root_i     = 6'd0;
      in_valid_i = 1'b1;
      tick();
      root_i = 6'd63;
      wait_valid(cyc);
      check("t2_latency0", cyc, W);
      check("t2_square0", square_o, 0);
      tick();
      check("t2_no_dup_valid", out_valid_o, 0);
      check("t2_in_ready", in_ready_o, 1);
      tick();
      in_valid_i = 1'b0;
      wait_valid(cyc);
      check("t2_latency63", cyc, W);
      check("t2_square63", square_o, 3969);
      tick();

      // 3: root=12, consumer stalls 5 cycles while in_valid pulses arrive
      out_ready_i = 1'b0;
      accept(6'd12);
      wait_valid(cyc);
      check("t3_square", square_o, 144);
      for (int i = 0; i < 5; i++) begin
         in_valid_i = (i % 2) == 0;
         root_i     = 6'd33;
         tick();
         check("t3_hold_valid", out_valid_o, 1);
         check("t3_hold_square", square_o, 144);
      end
      in_valid_i  = 1'b0;
      out_ready_i = 1'b1;
      tick();
      check("t3_released", out_valid_o, 0);
      check("t3_square_kept", square_o, 144);
      tick();
      check("t3_idle_after", in_ready_o, 1);

      // 4: root=50, asynchronous reset during the run
      accept(6'd50);
      tick();
      tick();
      tick();
      rst_i = 1'b1;
      #1;
      check("t4_rst_in_ready", in_ready_o, 1);
      check("t4_rst_out_valid", out_valid_o, 0);
      tick();
      rst_i = 1'b0;
      seen  = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (out_valid_o) seen++;
      end
      check("t4_no_pulse", seen, 0);
      accept(6'd7);
      wait_valid(cyc);
      check("t4_latency", cyc, W);
      check("t4_square", square_o, 49);
      tick();

`ifdef ANFSQRT_SQUARE_CHECK_EN
      // 5/6: range check against query=2047
      query_i = 12'd2047;
      accept(6'd45);
      wait_valid(cyc);
      check("t5_square", square_o, 2025);
      check("t5_rem", rem_o, 22);
      check("t5_root_ok", root_ok_o, 1);
      tick();
      accept(6'd44);
      wait_valid(cyc);
      check("t6_square", square_o, 1936);
      check("t6_rem", rem_o, 111);
      check("t6_root_ok", root_ok_o, 0);
      tick();
      accept(6'd46);
      wait_valid(cyc);
      check("t6b_square", square_o, 2116);
      check("t6b_rem", rem_o, 13'h1FBB);
      check("t6b_root_ok", root_ok_o, 0);
      tick();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
